// File: rtl/riscv_core_mul_iter.sv
// Iterative RV64IM multiplier (MUL/MULH/MULHSU/MULHU/MULW): magnitude shift-add
// datapath retiring RADIX_BITS bits per cycle, with a one-cycle path for 0/1/-1 operands.
module riscv_core_mul_iter #(
    parameter int XLEN       = 64,
    parameter int RADIX_BITS = 2
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_mul_valid,
    output logic            o_mul_ready,
    input  logic [XLEN-1:0] i_mul_srcA,
    input  logic [XLEN-1:0] i_mul_srcB,
    input  logic [1:0]      i_mul_control,
    input  logic            i_mul_isword,
    input  logic            i_mul_flush,
    output logic            o_mul_valid,
    input  logic            i_mul_res_ready,
    output logic [XLEN-1:0] o_mul_result,
    output logic            o_mul_busy,
    output logic [1:0]      o_dbg_state
);
    localparam int PW = 2 * XLEN;
    localparam int ND = XLEN / RADIX_BITS;
    localparam int NW = 32 / RADIX_BITS;
    localparam int IW = $clog2(ND) + 1;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_SIGN, S_DONE} state_t;

    state_t          r_state;
    logic [1:0]      r_ctrl;
    logic            r_isword;
    logic            r_neg;
    logic [PW-1:0]   r_mcand;
    logic [XLEN-1:0] r_mplier;
    logic [PW-1:0]   r_prod;
    logic [IW-1:0]   r_iter;
    logic [XLEN-1:0] r_result;

    logic            w_word, w_a_signed, w_b_signed, w_a_neg, w_b_neg;
    logic [XLEN-1:0] w_a_eff, w_b_eff, w_a_mag, w_b_mag;
    logic [PW-1:0]   w_a_ext, w_b_ext, w_fast_prod, w_pp, w_p_fix;
    logic            w_fast, w_last;

    // Word mode views each operand as its sign-extended low 32 bits, so all
    // fast-path comparisons and magnitudes work on one XLEN-wide value.
    assign w_word     = (XLEN == 64) && i_mul_isword;
    assign w_a_eff    = w_word ? XLEN'($signed(i_mul_srcA[31:0])) : i_mul_srcA;
    assign w_b_eff    = w_word ? XLEN'($signed(i_mul_srcB[31:0])) : i_mul_srcB;
    assign w_a_signed = w_word || (i_mul_control != 2'b11);
    assign w_b_signed = w_word || !i_mul_control[1];
    assign w_a_neg    = w_a_signed && w_a_eff[XLEN-1];
    assign w_b_neg    = w_b_signed && w_b_eff[XLEN-1];
    assign w_a_mag    = w_a_neg ? ~w_a_eff + XLEN'(1) : w_a_eff;
    assign w_b_mag    = w_b_neg ? ~w_b_eff + XLEN'(1) : w_b_eff;
    assign w_a_ext    = w_a_signed ? PW'($signed(w_a_eff)) : PW'(w_a_eff);
    assign w_b_ext    = w_b_signed ? PW'($signed(w_b_eff)) : PW'(w_b_eff);

    always_comb begin
        w_fast      = 1'b1;
        w_fast_prod = '0;
        if (w_a_eff == '0 || w_b_eff == '0)
            w_fast_prod = '0;
        else if (w_a_eff == XLEN'(1))
            w_fast_prod = w_b_ext;
        else if (w_b_eff == XLEN'(1))
            w_fast_prod = w_a_ext;
        else if (w_a_signed && (&w_a_eff))
            w_fast_prod = ~w_b_ext + PW'(1);
        else if (w_b_signed && (&w_b_eff))
            w_fast_prod = ~w_a_ext + PW'(1);
        else
            w_fast = 1'b0;
    end

    // The multiplicand shifts left each iteration, equivalent to shifting the partial product by iter*RADIX_BITS.
    assign w_pp    = r_mcand * PW'(r_mplier[RADIX_BITS-1:0]);
    assign w_last  = (r_iter == (r_isword ? IW'(NW - 1) : IW'(ND - 1)));
    assign w_p_fix = r_neg ? ~r_prod + PW'(1) : r_prod;

    function automatic logic [XLEN-1:0] sel_result(input logic [PW-1:0] p,
                                                   input logic [1:0] ctrl,
                                                   input logic word);
        if (word)
            return XLEN'($signed(p[31:0]));
        else if (ctrl == 2'b00)
            return p[XLEN-1:0];
        else
            return p[PW-1:XLEN];
    endfunction

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= S_IDLE;
            r_ctrl   <= '0;
            r_isword <= 1'b0;
            r_neg    <= 1'b0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_prod   <= '0;
            r_iter   <= '0;
            r_result <= '0;
        end else if (i_mul_flush) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_mul_valid) begin
                        r_ctrl   <= i_mul_control;
                        r_isword <= w_word;
                        r_neg    <= w_a_neg ^ w_b_neg;
                        r_mcand  <= PW'(w_a_mag);
                        r_mplier <= w_b_mag;
                        r_iter   <= '0;
                        if (w_fast) begin
                            r_prod   <= w_fast_prod;
                            r_result <= sel_result(w_fast_prod, i_mul_control, w_word);
                            r_state  <= S_DONE;
                        end else begin
                            r_prod  <= '0;
                            r_state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    r_prod   <= r_prod + w_pp;
                    r_mcand  <= r_mcand << RADIX_BITS;
                    r_mplier <= r_mplier >> RADIX_BITS;
                    r_iter   <= r_iter + IW'(1);
                    if (w_last)
                        r_state <= S_SIGN;
                end
                S_SIGN: begin
                    r_prod   <= w_p_fix;
                    r_result <= sel_result(w_p_fix, r_ctrl, r_isword);
                    r_state  <= S_DONE;
                end
                S_DONE: begin
                    if (i_mul_res_ready)
                        r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Request/result handshakes: a transfer happens on a rising edge where valid and ready are both high.
    assign o_mul_ready  = (r_state == S_IDLE);
    assign o_mul_valid  = (r_state == S_DONE);
    assign o_mul_busy   = (r_state != S_IDLE);
    assign o_mul_result = r_result;
    assign o_dbg_state  = r_state;
endmodule

// File: tb/tb_riscv_core_mul_iter.sv
// Directed and randomized bench for riscv_core_mul_iter, checked against a 128-bit arithmetic model.
module tb_riscv_core_mul_iter;
    localparam int XLEN = 64;
    localparam int R    = 2;

    // clock / reset
    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_mul_valid, i_mul_isword, i_mul_flush, i_mul_res_ready;
    logic [63:0] i_mul_srcA, i_mul_srcB;
    logic [1:0]  i_mul_control;
    logic        o_mul_ready, o_mul_valid, o_mul_busy;
    logic [63:0] o_mul_result;
    logic [1:0]  o_dbg_state;

    always #5 clk = ~clk;

    riscv_core_mul_iter #(.XLEN(XLEN), .RADIX_BITS(R)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_mul_valid(i_mul_valid), .o_mul_ready(o_mul_ready),
        .i_mul_srcA(i_mul_srcA), .i_mul_srcB(i_mul_srcB),
        .i_mul_control(i_mul_control), .i_mul_isword(i_mul_isword),
        .i_mul_flush(i_mul_flush), .o_mul_valid(o_mul_valid),
        .i_mul_res_ready(i_mul_res_ready), .o_mul_result(o_mul_result),
        .o_mul_busy(o_mul_busy), .o_dbg_state(o_dbg_state)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // reference model: full-width product of the extended operands
    function automatic logic [63:0] ref_mul(input logic [63:0] a, input logic [63:0] b,
                                            input logic [1:0] c, input logic w);
        logic [127:0] ea, eb, p;
        if (w) begin
            ea = {{96{a[31]}}, a[31:0]};
            eb = {{96{b[31]}}, b[31:0]};
            p  = ea * eb;
            return {{32{p[31]}}, p[31:0]};
        end
        ea = (c != 2'b11) ? {{64{a[63]}}, a} : {64'b0, a};
        eb = (c[1] == 1'b0) ? {{64{b[63]}}, b} : {64'b0, b};
        p  = ea * eb;
        return (c == 2'b00) ? p[63:0] : p[127:64];
    endfunction

    function automatic int ref_lat(input logic [63:0] a, input logic [63:0] b,
                                   input logic [1:0] c, input logic w);
        logic [63:0] av, bv;
        logic        as, bs, fast;
        av = w ? {{32{a[31]}}, a[31:0]} : a;
        bv = w ? {{32{b[31]}}, b[31:0]} : b;
        as = w || (c != 2'b11);
        bs = w || (c[1] == 1'b0);
        fast = (av == 0) || (bv == 0) || (av == 1) || (bv == 1) ||
               (as && av == '1) || (bs && bv == '1);
        return fast ? 1 : ((w ? 32 : 64) / R) + 2;
    endfunction

    function automatic logic [63:0] rnd_op();
        case ($urandom_range(0, 7))
            0: return 64'd0;
            1: return 64'd1;
            2: return '1;
            3: return 64'h8000_0000_0000_0000;
            4: return 64'($urandom_range(2, 1000));
            5: return {$urandom, 32'hFFFF_FFFF};
            6: return {$urandom, 32'h0000_0001};
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // driver tasks: every task starts and ends just after a falling edge
    task automatic issue(input logic [63:0] a, input logic [63:0] b,
                         input logic [1:0] c, input logic w);
        chk("ready_before_accept", {63'b0, o_mul_ready}, 64'd1);
        i_mul_valid = 1'b1; i_mul_srcA = a; i_mul_srcB = b;
        i_mul_control = c; i_mul_isword = w;
        @(negedge clk);
        i_mul_valid   = 1'b0;
        i_mul_srcA    = {$urandom, $urandom};
        i_mul_srcB    = {$urandom, $urandom};
        i_mul_control = 2'($urandom_range(0, 3));
        i_mul_isword  = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_valid(output int lat, output logic [63:0] res);
        lat = 0;
        res = '0;
        for (int k = 1; k <= 200; k++) begin
            if (o_mul_valid) begin
                lat = k;
                res = o_mul_result;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic handshake();
        i_mul_res_ready = 1'b1;
        @(negedge clk);
        i_mul_res_ready = 1'b0;
    endtask

    // scoreboard step: one operation checked for value and latency
    task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                          input logic [1:0] c, input logic w, output logic [63:0] res,
                          output int lat);
        logic [63:0] exp_q[$];
        exp_q.push_back(ref_mul(a, b, c, w));
        exp_q.push_back(64'(ref_lat(a, b, c, w)));
        issue(a, b, c, w);
        wait_valid(lat, res);
        chk({tag, "_res"}, res, exp_q.pop_front());
        chk({tag, "_lat"}, 64'(lat), exp_q.pop_front());
        if (lat != 0) handshake();
    endtask

    initial begin
        logic [63:0] res, held;
        int          lat;
        logic        seen;
        rst_n = 1'b0; i_mul_valid = 1'b0; i_mul_srcA = '0; i_mul_srcB = '0;
        i_mul_control = '0; i_mul_isword = 1'b0; i_mul_flush = 1'b0; i_mul_res_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", {63'b0, o_mul_ready}, 64'd1);
        chk("rst_valid", {63'b0, o_mul_valid}, 64'd0);
        chk("rst_busy", {63'b0, o_mul_busy}, 64'd0);
        chk("rst_result", o_mul_result, 64'd0);

        run_op("mul_7x-3", 64'd7, -64'sd3, 2'b00, 1'b0, res, lat);
        chk("mul_7x-3_const", res, 64'hFFFF_FFFF_FFFF_FFEB);
        chk("mul_7x-3_lat34", 64'(lat), 64'd34);
        run_op("mulh_min", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 2'b01, 1'b0, res, lat);
        chk("mulh_min_const", res, 64'h4000_0000_0000_0000);
        run_op("mulhsu_min", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 2'b10, 1'b0, res, lat);
        chk("mulhsu_min_const", res, 64'hC000_0000_0000_0000);
        run_op("mulhu_min", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 2'b11, 1'b0, res, lat);
        chk("mulhu_min_const", res, 64'h4000_0000_0000_0000);
        run_op("mulh_min_x_m1", 64'h8000_0000_0000_0000, '1, 2'b01, 1'b0, res, lat);
        chk("mulh_min_x_m1_const", res, 64'd0);
        chk("mulh_min_x_m1_lat1", 64'(lat), 64'd1);
        run_op("mul_min_x_m1", 64'h8000_0000_0000_0000, '1, 2'b00, 1'b0, res, lat);
        chk("mul_min_x_m1_const", res, 64'h8000_0000_0000_0000);
        run_op("mulw_junk", 64'hDEAD_BEEF_7FFF_FFFF, 64'h1234_5678_0000_0002, 2'b00, 1'b1, res, lat);
        chk("mulw_junk_const", res, 64'hFFFF_FFFF_FFFF_FFFE);
        chk("mulw_junk_lat18", 64'(lat), 64'd18);
        run_op("mul_b0", 64'h1234_5678_9ABC_DEF0, 64'd0, 2'b00, 1'b0, res, lat);
        chk("mul_b0_lat1", 64'(lat), 64'd1);
        run_op("mulhu_ones_x2", '1, 64'd2, 2'b11, 1'b0, res, lat);
        chk("mulhu_ones_x2_const", res, 64'd1);
        chk("mulhu_ones_x2_lat34", 64'(lat), 64'd34);

        // result held while the consumer stalls
        issue(64'd123456789, 64'd987654321, 2'b00, 1'b0);
        wait_valid(lat, held);
        chk("stall_res", held, ref_mul(64'd123456789, 64'd987654321, 2'b00, 1'b0));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_valid", {63'b0, o_mul_valid}, 64'd1);
            chk("stall_hold", o_mul_result, held);
        end
        handshake();

        // flush during CALC iteration 10
        issue(64'd12345, 64'd6789, 2'b00, 1'b0);
        repeat (10) @(negedge clk);
        chk("flush_busy_before", {63'b0, o_mul_busy}, 64'd1);
        i_mul_flush = 1'b1;
        @(negedge clk);
        i_mul_flush = 1'b0;
        chk("flush_ready", {63'b0, o_mul_ready}, 64'd1);
        chk("flush_busy", {63'b0, o_mul_busy}, 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            seen |= o_mul_valid;
            @(negedge clk);
        end
        chk("flush_no_valid", {63'b0, seen}, 64'd0);

        // flush coincident with a request in IDLE
        i_mul_valid = 1'b1; i_mul_flush = 1'b1;
        i_mul_srcA = 64'd5; i_mul_srcB = 64'd9; i_mul_control = 2'b00; i_mul_isword = 1'b0;
        @(negedge clk);
        i_mul_valid = 1'b0; i_mul_flush = 1'b0;
        chk("flush_acc_busy", {63'b0, o_mul_busy}, 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            seen |= o_mul_valid;
            @(negedge clk);
        end
        chk("flush_acc_no_valid", {63'b0, seen}, 64'd0);

        // asynchronous reset during CALC
        issue(64'd1000003, 64'd777, 2'b00, 1'b0);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_ready", {63'b0, o_mul_ready}, 64'd1);
        chk("midrst_valid", {63'b0, o_mul_valid}, 64'd0);
        chk("midrst_busy", {63'b0, o_mul_busy}, 64'd0);
        chk("midrst_result", o_mul_result, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op("post_rst", 64'd1000003, 64'd777, 2'b00, 1'b0, res, lat);

        // randomized operations
        for (int n = 0; n < 60; n++) begin
            logic [63:0] a, b;
            logic [1:0]  c;
            logic        w;
            a = rnd_op();
            b = rnd_op();
            c = 2'($urandom_range(0, 3));
            w = (c == 2'b00) && ($urandom_range(0, 1) == 1);
            run_op($sformatf("rnd%0d", n), a, b, c, w, res, lat);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/riscv_core_mul_iter.md
# riscv_core_mul_iter

Iterative, parametrised integer multiplier for the RV64IM execute stage, covering MUL, MULH, MULHSU, MULHU and MULW. Operands are converted to magnitudes, multiplied by an unsigned shift-add datapath that retires RADIX_BITS multiplier bits per cycle, and sign-corrected at the end. Trivial operands (0, 1, -1) take a one-cycle fast path. Requests and results use valid/ready handshakes, and a flush input lets the pipeline kill an in-flight operation.

## Interface
- XLEN, 64: datapath width; legal values are 32 and 64.
- RADIX_BITS, 2: multiplier bits retired per iteration; legal values are 1, 2 and 4.
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst_n  in  1  reset; asynchronous assert, active-low, synchronous release is external.
- i_mul_valid  in  1  request valid.
- o_mul_ready  out  1  unit idle and able to accept a request.
- i_mul_srcA  in  XLEN  rs1 operand.
- i_mul_srcB  in  XLEN  rs2 operand.
- i_mul_control  in  2  operation: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
- i_mul_isword  in  1  MULW; only legal with control 00. Ignored when XLEN=32.
- i_mul_flush  in  1  abort the current operation.
- o_mul_valid  out  1  result valid.
- i_mul_res_ready  in  1  consumer accepts the result.
- o_mul_result  out  XLEN  result.
- o_mul_busy  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, CALC, SIGN, DONE.
- Accept condition: i_mul_valid && o_mul_ready && !i_mul_flush. On accept, the unit latches control, isword, the operand magnitudes and the result sign.
- Signedness:
  - MUL and MULH: both operands signed.
  - MULHSU: A signed, B unsigned.
  - MULHU: both unsigned.
  - MULW: the low 32 bits of each operand are used, both signed.
- Magnitude: a signed operand with its MSB set is replaced by its two's complement (~x+1). The MSB is bit 31 in word mode.
- neg = signA XOR signB, where each sign bit counts only if that operand is signed.
- Fast path, evaluated in IDLE on accept. Comparisons use the 32-bit view in word mode.
  - Either operand == 0: product = 0.
  - A == 1: product = B, extended according to B's signedness.
  - B == 1: product = A, extended according to A's signedness.
  - A == all-ones with A signed: product = -(B extended).
  - B == all-ones with B signed: product = -(A extended).
  - Priority order: zero, then A==1, then B==1, then A==-1, then B==-1.
  - The product is formed at width 2*XLEN. The next state is DONE.
- CALC:
  - Product register P is 2*XLEN wide, cleared on entry.
  - Each cycle: P += mcand * mplier[RADIX_BITS-1:0] << (iter*RADIX_BITS), then mplier >>= RADIX_BITS, iter++.
  - Iteration count N = XLEN/RADIX_BITS, or 32/RADIX_BITS in word mode.
  - After the last iteration the next state is SIGN.
- SIGN: if neg, P = ~P+1 over the full 2*XLEN bits. The next state is DONE.
- Result select:
  - MUL: P[XLEN-1:0].
  - MULH, MULHSU, MULHU: P[2*XLEN-1:XLEN].
  - MULW: sign-extend P[31:0] to XLEN.
- DONE:
  - o_mul_valid is high.
  - o_mul_result is held stable until i_mul_res_ready.
  - When i_mul_res_ready is high, the next state is IDLE.
- Flush:
  - i_mul_flush high in any state forces IDLE on the next edge and drops o_mul_valid.
  - Flush wins over a simultaneous accept and over a simultaneous result handshake.
- Reset values:
  - State IDLE.
  - o_mul_ready = 1.
  - o_mul_valid = 0.
  - o_mul_busy = 0.
  - o_mul_result = 0.
  - P, iteration counter and latched fields all cleared.
  - Reset mid-operation discards all work.

## Timing
- Accept at edge t.
- Fast path: o_mul_valid is high from edge t+1.
- Normal path: CALC occupies cycles t+1 to t+N, SIGN occupies t+N+1, and o_mul_valid is high from edge t+N+2.
- Latency examples:
  - XLEN=64, RADIX_BITS=2: 34 cycles for doubleword operations, 18 for MULW.
  - RADIX_BITS=4: 18 and 10.
- o_mul_ready = (state == IDLE). It is a registered decode only, with no combinational path from i_mul_valid.
- Back-to-back: a result handshake at edge u gives IDLE at u+1. The next accept can occur at edge u+1.
- Inputs are sampled only on the accept edge. Operand changes afterwards have no effect.

## Test plan
- MUL normal path: A=7, B=-3, XLEN=64, RADIX_BITS=2 -> o_mul_valid exactly 34 cycles after accept, result 0xFFFFFFFFFFFFFFEB.
- MULH, MULHSU and MULHU: A=B=0x8000000000000000 -> MULH 0x4000000000000000, MULHSU 0xC000000000000000, MULHU 0x4000000000000000.
- MULH corner: A=0x8000000000000000 with B=-1 -> fast path, valid after 1 cycle, MULH 0, MUL 0x8000000000000000.
- MULW: A=0x00000000_7FFFFFFF, B=2 -> 0xFFFFFFFFFFFFFFFE after 18 cycles. Upper operand bits set to junk do not change the result.
- Fast paths: B=0 -> 0 after 1 cycle. With MULHU and A=all-ones, B=2 -> no fast path, full latency, result 1.
- Handshake, flush and reset:
  - Hold i_mul_res_ready low for 5 cycles -> result stable throughout.
  - Flush at CALC iteration 10 -> IDLE next cycle, no o_mul_valid.
  - Flush coincident with i_mul_valid in IDLE -> no accept.
  - Drive i_rst_n low mid-CALC -> all outputs take their reset values immediately.
